// File: rtl/dram_rw_sequencer.sv
// Self-test sequencer for the 16-core DRAM write/read datapath: writes a per-row
// byte pattern, reads the row back, and accumulates byte mismatch statistics.
module dram_rw_sequencer #(
    parameter int NUM_ROWS = 64,
    parameter int TIMEOUT  = 4096
) (
    input  logic         clk_100m,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   pattern_sel,
    output logic         io_en,
    output logic [1:0]   io_model,
    output logic [5:0]   wwl_add,
    output logic [5:0]   rwl_add,
    output logic [63:0]  wbl_data,
    input  logic         wt_done,
    input  logic         rd_done,
    input  logic [127:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic [15:0]  err_cnt,
    output logic         fail_valid,
    output logic [5:0]   fail_addr,
    output logic [5:0]   first_fail_addr,
    output logic         timeout_err
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WR_SETUP = 4'd1;
    localparam logic [3:0] WR_STB   = 4'd2;
    localparam logic [3:0] WR_WAIT  = 4'd3;
    localparam logic [3:0] RD_SETUP = 4'd4;
    localparam logic [3:0] RD_STB   = 4'd5;
    localparam logic [3:0] RD_WAIT  = 4'd6;
    localparam logic [3:0] CHECK    = 4'd7;
    localparam logic [3:0] NEXT     = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [5:0]    LAST_ROW  = 6'(NUM_ROWS - 1);

    logic [3:0]    state, next_state;
    logic [5:0]    row, next_row;
    logic [1:0]    pat, next_pat;
    logic [CW-1:0] wait_cnt;
    logic [127:0]  cap;
    logic          fail_seen;
    logic          start_ok;
    logic          wait_expired;
    logic [7:0]    cur_exp, next_exp;
    logic [4:0]    mism;
    logic [16:0]   err_sum;

    function automatic logic [7:0] pattern_byte(input logic [1:0] sel, input logic [5:0] r);
        logic [7:0] b;
        case (sel)
            2'd0:    b = 8'h55;
            2'd1:    b = 8'hAA;
            2'd2:    b = {2'b00, r};
            default: b = ~{2'b00, r};
        endcase
        return b;
    endfunction

    assign start_ok     = (state == IDLE) && start;
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign cur_exp      = pattern_byte(pat, row);
    assign next_exp     = pattern_byte(next_pat, next_row);
    assign err_sum      = {1'b0, err_cnt} + 17'(mism);

    always_comb begin
        mism = '0;
        for (int k = 0; k < 16; k++) begin
            if (cap[8*k +: 8] != cur_exp) begin
                mism = mism + 5'd1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        next_state = state;
        next_row   = row;
        next_pat   = pat;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WR_SETUP;
                    next_row   = '0;
                    next_pat   = pattern_sel;
                end
            end
            WR_SETUP: next_state = WR_STB;
            WR_STB:   next_state = WR_WAIT;
            WR_WAIT: begin
                if (wt_done)           next_state = RD_SETUP;
                else if (wait_expired) next_state = DONE;
            end
            RD_SETUP: next_state = RD_STB;
            RD_STB:   next_state = RD_WAIT;
            RD_WAIT: begin
                if (rd_done)           next_state = CHECK;
                else if (wait_expired) next_state = DONE;
            end
            CHECK: next_state = NEXT;
            NEXT: begin
                if (row == LAST_ROW) begin
                    next_state = DONE;
                end else begin
                    next_row   = row + 6'd1;
                    next_state = WR_SETUP;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            row             <= '0;
            pat             <= '0;
            wait_cnt        <= '0;
            cap             <= '0;
            fail_seen       <= 1'b0;
            io_en           <= 1'b0;
            io_model        <= 2'b00;
            wwl_add         <= '0;
            rwl_add         <= '0;
            wbl_data        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_cnt         <= '0;
            fail_valid      <= 1'b0;
            fail_addr       <= '0;
            first_fail_addr <= '0;
            timeout_err     <= 1'b0;
        end else begin
            state <= next_state;
            row   <= next_row;
            pat   <= next_pat;

            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (state == WR_WAIT || state == RD_WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            io_en <= (next_state == WR_STB) || (next_state == RD_STB);
            case (next_state)
                WR_SETUP, WR_STB, WR_WAIT: io_model <= 2'b01;
                RD_SETUP, RD_STB, RD_WAIT: io_model <= 2'b10;
                default:                   io_model <= 2'b00;
            endcase

            if (next_state == WR_SETUP) begin
                wwl_add  <= next_row;
                wbl_data <= {8{next_exp}};
            end
            if (next_state == RD_SETUP) begin
                rwl_add <= next_row;
            end

            busy <= (next_state != IDLE);
            done <= (next_state == DONE);

            if (state == RD_WAIT && rd_done) begin
                cap <= rd_data;
            end

            fail_valid <= 1'b0;
            if (start_ok) begin
                err_cnt         <= '0;
                first_fail_addr <= '0;
                timeout_err     <= 1'b0;
                fail_seen       <= 1'b0;
            end else if (state == CHECK) begin
                err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if (mism != 5'd0) begin
                    fail_valid <= 1'b1;
                    fail_addr  <= row;
                    if (!fail_seen) begin
                        first_fail_addr <= row;
                        fail_seen       <= 1'b1;
                    end
                end
            end

            // A wait state leaving straight for DONE can only mean the wait expired.
            if ((state == WR_WAIT || state == RD_WAIT) && next_state == DONE) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
